main_memory: RTL and testbench

- Byte-addressed, big-endian, synchronous main memory for the MIPS processor.
- Serves both instruction fetch and data access.
- Supports single-word and fixed-length burst reads and writes through a simple enable/busy handshake.
- The address window starts at START_ADDR; accesses outside the window are harmless.

---
 rtl/main_memory.sv | 93 +++++++++
 tb/tb_main_memory.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/main_memory.sv
// main_memory: byte-addressed big-endian memory with single-word and burst access via an enable/busy handshake.
module main_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DEPTH = 1048576,
  parameter logic [ADDRESS_WIDTH-1:0] START_ADDR = 32'h80020000
`ifdef MEMORY_PRELOAD_EN
  , parameter string INIT_FILE = "program.hex"
`endif
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [ADDRESS_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic [1:0]               access_size,
  input  logic                     rw,
  input  logic                     enable,
  output logic                     busy,
  output logic [DATA_WIDTH-1:0]    data_out
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [0:DEPTH-1] = '{default: 8'h00};
  logic                     busy_q, busy_d;
  logic [3:0]               beat_q, beat_d, last_q, last_d;
  logic [AW-1:0]            base_q, base_d;
  logic                     rw_q, rw_d, hit_q, hit_d;
  logic [DATA_WIDTH-1:0]    data_out_q, data_out_d;
  logic [ADDRESS_WIDTH-1:0] rel;
  logic [AW-1:0]            off;
  logic [3:0]               last_req;
  logic                     hit, rd, wr;
  always_comb begin
    rel = (address - START_ADDR) & ~ADDRESS_WIDTH'(3);
    last_req = access_size == 2'b00 ? 4'd0 : access_size == 2'b01 ? 4'd3 :
               access_size == 2'b10 ? 4'd7 : 4'd15;
    busy_d = busy_q;
    beat_d = beat_q;
    last_d = last_q;
    base_d = base_q;
    rw_d = rw_q;
    hit_d = hit_q;
    if (busy_q) begin
      off = base_q + AW'({beat_q, 2'b00});
      hit = hit_q;
      rd = rw_q;
      wr = ~rw_q;
      busy_d = beat_q != last_q;
      beat_d = busy_d ? beat_q + 4'd1 : 4'd0;
    end else begin
      off = rel[AW-1:0];
      hit = rel < DEPTH;
      rd = enable & rw;
      wr = enable & ~rw;
      if (enable && last_req != 4'd0) begin
        busy_d = 1'b1;
        beat_d = 4'd1;
        last_d = last_req;
        base_d = rel[AW-1:0];
        rw_d = rw;
        hit_d = hit;
      end
    end
    data_out_d = rd ? (hit ? {mem[off], mem[off+AW'(1)], mem[off+AW'(2)], mem[off+AW'(3)]} : '0)
                    : data_out_q;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      busy_q <= 1'b0;
      beat_q <= '0;
      last_q <= '0;
      base_q <= '0;
      rw_q <= 1'b0;
      hit_q <= 1'b0;
      data_out_q <= '0;
    end else begin
      busy_q <= busy_d;
      beat_q <= beat_d;
      last_q <= last_d;
      base_q <= base_d;
      rw_q <= rw_d;
      hit_q <= hit_d;
      data_out_q <= data_out_d;
    end
  always_ff @(posedge clock)
    if (reset_n && wr && hit) begin
      mem[off] <= data_in[31:24];
      mem[off+AW'(1)] <= data_in[23:16];
      mem[off+AW'(2)] <= data_in[15:8];
      mem[off+AW'(3)] <= data_in[7:0];
    end
  assign busy = busy_q;
  assign data_out = data_out_q;
endmodule

// File: tb/tb_main_memory.sv
// tb_main_memory: directed scenario tasks for main_memory with hand-computed expectations.
module tb_main_memory;
  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] address = '0;
  logic [31:0] data_in = '0;
  logic [1:0]  access_size = '0;
  logic        rw = 1'b0;
  logic        enable = 1'b0;
  logic        busy;
  logic [31:0] data_out;
  int checks = 0;
  int passed = 0;

  main_memory dut (
    .clock(clock), .reset_n(reset_n), .address(address), .data_in(data_in),
    .access_size(access_size), .rw(rw), .enable(enable), .busy(busy), .data_out(data_out)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    step();
    #2 reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    checks++; if (data_out !== 32'h0) $display("FAIL reset_data got %h want 0", data_out); else passed++;
    step();
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    checks++; if (busy !== 1'b0) $display("FAIL idle_busy got %b want 0", busy); else passed++;
    checks++; if (data_out !== 32'h0) $display("FAIL idle_data got %h want 0", data_out); else passed++;
  endtask

  task automatic test_single();
    address = 32'h80020000; data_in = 32'hDEADBEEF; access_size = 2'b00; rw = 1'b0; enable = 1'b1;
    step();
    checks++; if (busy !== 1'b0) $display("FAIL single_wr_busy got %b want 0", busy); else passed++;
    checks++; if (data_out !== 32'h0) $display("FAIL single_wr_data got %h want 0", data_out); else passed++;
    rw = 1'b1;
    step();
    enable = 1'b0;
    checks++; if (data_out !== 32'hDEADBEEF) $display("FAIL single_rd got %h want deadbeef", data_out); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL single_rd_busy got %b want 0", busy); else passed++;
    checks++; if (dut.mem[0] !== 8'hDE) $display("FAIL byte0 got %h want de", dut.mem[0]); else passed++;
    checks++; if (dut.mem[3] !== 8'hEF) $display("FAIL byte3 got %h want ef", dut.mem[3]); else passed++;
    step();
    checks++; if (data_out !== 32'hDEADBEEF) $display("FAIL hold got %h want deadbeef", data_out); else passed++;
  endtask

  task automatic test_burst4();
    int hi;
    hi = 0;
    address = 32'h80020010; access_size = 2'b01; rw = 1'b0; enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_in = 32'(i + 1);
      step();
      hi += int'(busy);
      enable = 1'b0;
    end
    checks++; if (hi != 3) $display("FAIL b4_wr_busy got %0d cycles want 3", hi); else passed++;
    checks++; if (data_out !== 32'hDEADBEEF) $display("FAIL b4_wr_data_out got %h want deadbeef", data_out); else passed++;
    hi = 0;
    rw = 1'b1; enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      enable = 1'b0;
      hi += int'(busy);
      checks++;
      if (data_out !== 32'(i + 1)) $display("FAIL b4_rd[%0d] got %h want %h", i, data_out, 32'(i + 1));
      else passed++;
    end
    checks++; if (hi != 3) $display("FAIL b4_rd_busy got %0d cycles want 3", hi); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL b4_end_busy got %b want 0", busy); else passed++;
  endtask

  task automatic test_burst16();
    logic [31:0] exp [16];
    int hi;
    hi = 0;
    for (int i = 0; i < 16; i++) exp[i] = 32'h0;
    exp[0] = 32'hDEADBEEF;
    exp[4] = 32'd1; exp[5] = 32'd2; exp[6] = 32'd3; exp[7] = 32'd4;
    step();
    address = 32'h80020000; access_size = 2'b11; rw = 1'b1; enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 5) begin
        address = 32'h80020000; access_size = 2'b00; rw = 1'b0; data_in = 32'hFFFFFFFF;
      end
      if (i == 15) begin
        address = 32'h80020010; access_size = 2'b00; rw = 1'b1;
      end
      step();
      hi += int'(busy);
      checks++;
      if (data_out !== exp[i]) $display("FAIL b16_rd[%0d] got %h want %h", i, data_out, exp[i]);
      else passed++;
    end
    checks++; if (hi != 15) $display("FAIL b16_busy got %0d cycles want 15", hi); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL b16_clear got %b want 0", busy); else passed++;
    step();
    enable = 1'b0;
    checks++; if (data_out !== 32'd1) $display("FAIL b16_next got %h want 1", data_out); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL b16_next_busy got %b want 0", busy); else passed++;
  endtask

  task automatic test_out_of_range();
    address = 32'h80000000; data_in = 32'h12345678; access_size = 2'b00; rw = 1'b0; enable = 1'b1;
    step();
    rw = 1'b1;
    step();
    checks++; if (data_out !== 32'h0) $display("FAIL oor_rd got %h want 0", data_out); else passed++;
    address = 32'h80020000;
    step();
    enable = 1'b0;
    checks++; if (data_out !== 32'hDEADBEEF) $display("FAIL oor_start got %h want deadbeef", data_out); else passed++;
  endtask

  task automatic test_reset_burst();
    logic [31:0] exp [8];
    for (int i = 0; i < 8; i++) exp[i] = (i < 3) ? 32'hA0 + 32'(i) : 32'h0;
    address = 32'h80020100; access_size = 2'b10; rw = 1'b0; enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_in = 32'hA0 + 32'(i);
      step();
      enable = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL rb_busy got %b want 0", busy); else passed++;
    for (int i = 3; i < 6; i++) begin
      data_in = 32'hA0 + 32'(i);
      step();
    end
    reset_n = 1'b1;
    for (int i = 6; i < 9; i++) begin
      data_in = 32'hA0 + 32'(i);
      step();
    end
    checks++; if (busy !== 1'b0) $display("FAIL rb_idle_busy got %b want 0", busy); else passed++;
    address = 32'h80020100; access_size = 2'b10; rw = 1'b1; enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      enable = 1'b0;
      checks++;
      if (data_out !== exp[i]) $display("FAIL rb_rd[%0d] got %h want %h", i, data_out, exp[i]);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst4();
    test_burst16();
    test_out_of_range();
    test_reset_burst();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
